branch_update_ctrl: RTL and testbench

BRANCH_UPDATE_CTRL -- requirements
Module: branch_update_ctrl

---
 rtl/bp_pkg.sv | 21 ++
 rtl/bp_upd_fifo.sv | 58 +++++
 rtl/branch_update_ctrl.sv | 106 ++++++++++
 tb/tb_branch_update_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch-predictor update path: widths, branch
// type encodings and the drain-sequencer state type.
package bp_pkg;

  localparam int ADDR_W    = 32;
  localparam int BHR_W_DEF = 4;

  typedef enum logic [1:0] {
    BR_DIRECT   = 2'b00,
    BR_CALL     = 2'b01,
    BR_RETURN   = 2'b10,
    BR_INDIRECT = 2'b11
  } br_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } drain_state_e;

endpackage

// File: rtl/bp_upd_fifo.sv
// Update-queue storage: up to two writes (port a, then port b) and one read
// per cycle, with an occupancy count. The caller guarantees space for writes.
module bp_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       wr0_en,
  input  logic [W-1:0]               wr0_data,
  input  logic                       wr1_en,
  input  logic [W-1:0]               wr1_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic             w_wa_en;
  logic [W-1:0]     w_wa_data;
  logic             w_wb_en;
  logic             w_rd;
  logic [CNT_W-1:0] w_n_wr;

  // A lone slot-1 commit takes the first free location, keeping program order.
  assign w_wa_en   = wr0_en | wr1_en;
  assign w_wa_data = wr0_en ? wr0_data : wr1_data;
  assign w_wb_en   = wr0_en & wr1_en;
  assign w_rd      = rd_en && (r_count != '0);
  assign w_n_wr    = CNT_W'(w_wa_en) + CNT_W'(w_wb_en);

  always_ff @(posedge clk) begin
    if (w_wa_en) r_mem[r_wptr] <= w_wa_data;
    if (w_wb_en) r_mem[r_wptr + PTR_W'(1)] <= wr1_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + PTR_W'(w_n_wr);
      r_rptr  <= r_rptr + PTR_W'(w_rd);
      r_count <= r_count + w_n_wr - CNT_W'(w_rd);
    end
  end

  assign rd_data = r_mem[r_rptr];
  assign count   = r_count;

endmodule

// File: rtl/branch_update_ctrl.sv
// Collects resolved branches from two commit slots into a small queue and
// streams them to the predictor tables; a drain sequencer flushes on request.
module branch_update_ctrl
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int BHR_W = BHR_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              c0_valid,
  input  logic [ADDR_W-1:0] c0_pc,
  input  logic [ADDR_W-1:0] c0_target,
  input  logic              c0_taken,
  input  logic [1:0]        c0_type,
  input  logic [BHR_W-1:0]  c0_bhr,
  input  logic              c1_valid,
  input  logic [ADDR_W-1:0] c1_pc,
  input  logic [ADDR_W-1:0] c1_target,
  input  logic              c1_taken,
  input  logic [1:0]        c1_type,
  input  logic [BHR_W-1:0]  c1_bhr,
  output logic              c_ready,
  output logic              upd_en,
  input  logic              upd_ready,
  output logic [ADDR_W-1:0] upd_pc,
  output logic [ADDR_W-1:0] upd_target,
  output logic              upd_taken,
  output logic [1:0]        upd_type,
  output logic [BHR_W-1:0]  upd_bhr,
  input  logic              drain_req,
  output logic              drain_busy,
  output logic              drain_done
);
  localparam int ENT_W = 2 * ADDR_W + 1 + 2 + BHR_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ENT_W-1:0] w_c0_ent;
  logic [ENT_W-1:0] w_c1_ent;
  logic [ENT_W-1:0] w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_space_ok;
  logic             w_wr0;
  logic             w_wr1;
  logic             w_deq;

  drain_state_e r_state;
  drain_state_e w_state_nxt;

  assign w_c0_ent = {c0_pc, c0_target, c0_taken, c0_type, c0_bhr};
  assign w_c1_ent = {c1_pc, c1_target, c1_taken, c1_type, c1_bhr};

  // Readiness comes from the registered count only, so a same-cycle dequeue
  // never creates a combinational path from upd_ready to c_ready.
  assign w_space_ok = (CNT_W'(DEPTH) - w_count) >= CNT_W'(2);
  assign c_ready    = w_space_ok && !drain_busy;
  assign w_wr0      = c0_valid && c_ready;
  assign w_wr1      = c1_valid && c_ready;
  assign upd_en     = (w_count != '0);
  assign w_deq      = upd_en && upd_ready;

  // Storage is unreset, so the payload is masked until a valid head exists.
  assign {upd_pc, upd_target, upd_taken, upd_type, upd_bhr} =
    upd_en ? w_head : {ENT_W{1'b0}};

  bp_upd_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .wr0_en   (w_wr0),
    .wr0_data (w_c0_ent),
    .wr1_en   (w_wr1),
    .wr1_data (w_c1_ent),
    .rd_en    (w_deq),
    .rd_data  (w_head),
    .count    (w_count)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (drain_req) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_count == '0) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    drain_busy = 1'b0;
    drain_done = 1'b0;
    case (r_state)
      ST_DRAIN: drain_busy = 1'b1;
      ST_DONE:  drain_done = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_branch_update_ctrl.sv
// Bench for branch_update_ctrl: directed vector table, wrap and reset
// sequences, then random traffic against a queue-based reference model.
module tb_branch_update_ctrl;
  logic        clk = 1'b0;
  logic        resetn;
  logic        c0_valid, c1_valid, c0_taken, c1_taken;
  logic [31:0] c0_pc, c0_target, c1_pc, c1_target;
  logic [1:0]  c0_type, c1_type;
  logic [3:0]  c0_bhr, c1_bhr;
  logic        c_ready, upd_en, upd_ready, upd_taken;
  logic [31:0] upd_pc, upd_target;
  logic [1:0]  upd_type;
  logic [3:0]  upd_bhr;
  logic        drain_req, drain_busy, drain_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_update_ctrl #(.DEPTH(4), .BHR_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .c0_valid(c0_valid), .c0_pc(c0_pc), .c0_target(c0_target),
    .c0_taken(c0_taken), .c0_type(c0_type), .c0_bhr(c0_bhr),
    .c1_valid(c1_valid), .c1_pc(c1_pc), .c1_target(c1_target),
    .c1_taken(c1_taken), .c1_type(c1_type), .c1_bhr(c1_bhr),
    .c_ready(c_ready), .upd_en(upd_en), .upd_ready(upd_ready),
    .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .upd_type(upd_type), .upd_bhr(upd_bhr),
    .drain_req(drain_req), .drain_busy(drain_busy), .drain_done(drain_done)
  );

  typedef struct {
    logic        c0v;
    logic [31:0] c0pc;
    logic        c1v;
    logic [31:0] c1pc;
    logic        rdy;
    logic        dreq;
    logic        e_en;
    logic [31:0] e_pc;
    logic        e_cr;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic [1:0]  typ;
    logic [3:0]  bhr;
  } ent_t;

  vec_t tbl[26];

  function automatic vec_t mk(logic c0v, logic [31:0] c0pc, logic c1v, logic [31:0] c1pc,
                              logic rdy, logic dreq, logic e_en, logic [31:0] e_pc,
                              logic e_cr, logic e_busy, logic e_done);
    vec_t v;
    v.c0v = c0v; v.c0pc = c0pc; v.c1v = c1v; v.c1pc = c1pc;
    v.rdy = rdy; v.dreq = dreq; v.e_en = e_en; v.e_pc = e_pc;
    v.e_cr = e_cr; v.e_busy = e_busy; v.e_done = e_done;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Payload fields other than pc are derived from pc for the directed tests.
  task automatic drive_slots(input logic v0, input logic [31:0] p0,
                             input logic v1, input logic [31:0] p1);
    c0_valid = v0; c0_pc = p0; c0_target = p0 + 32'h100;
    c0_taken = p0[2]; c0_type = p0[5:4]; c0_bhr = p0[7:4];
    c1_valid = v1; c1_pc = p1; c1_target = p1 + 32'h100;
    c1_taken = p1[2]; c1_type = p1[5:4]; c1_bhr = p1[7:4];
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  ent_t        mq[$];
  logic        m_busy, m_done;
  int          sent, recv;
  logic [31:0] exp_pc;

  initial begin
    resetn = 1'b0; upd_ready = 1'b0; drain_req = 1'b0;
    drive_slots(0, 0, 0, 0);

    tbl[0]  = mk(1, 'h100, 0, 0,     1, 0, 0, 0,     1, 0, 0);
    tbl[1]  = mk(0, 0,     0, 0,     1, 0, 1, 'h100, 1, 0, 0);
    tbl[2]  = mk(0, 0,     0, 0,     1, 0, 0, 0,     1, 0, 0);
    tbl[3]  = mk(1, 'h10,  1, 'h20,  1, 0, 0, 0,     1, 0, 0);
    tbl[4]  = mk(0, 0,     0, 0,     1, 0, 1, 'h10,  1, 0, 0);
    tbl[5]  = mk(0, 0,     0, 0,     1, 0, 1, 'h20,  1, 0, 0);
    tbl[6]  = mk(1, 'h30,  1, 'h34,  0, 0, 0, 0,     1, 0, 0);
    tbl[7]  = mk(1, 'h38,  1, 'h3C,  0, 0, 1, 'h30,  1, 0, 0);
    tbl[8]  = mk(1, 'h40,  1, 'h44,  0, 0, 1, 'h30,  0, 0, 0);
    tbl[9]  = mk(0, 0,     0, 0,     0, 0, 1, 'h30,  0, 0, 0);
    tbl[10] = mk(0, 0,     0, 0,     1, 0, 1, 'h30,  0, 0, 0);
    tbl[11] = mk(0, 0,     0, 0,     1, 0, 1, 'h34,  0, 0, 0);
    tbl[12] = mk(0, 0,     0, 0,     1, 0, 1, 'h38,  1, 0, 0);
    tbl[13] = mk(0, 0,     0, 0,     1, 0, 1, 'h3C,  1, 0, 0);
    tbl[14] = mk(0, 0,     0, 0,     1, 0, 0, 0,     1, 0, 0);
    tbl[15] = mk(1, 'h50,  1, 'h54,  0, 0, 0, 0,     1, 0, 0);
    tbl[16] = mk(1, 'h58,  0, 0,     0, 0, 1, 'h50,  1, 0, 0);
    tbl[17] = mk(0, 0,     0, 0,     1, 1, 1, 'h50,  0, 0, 0);
    tbl[18] = mk(1, 'h99,  0, 0,     1, 0, 1, 'h54,  0, 1, 0);
    tbl[19] = mk(0, 0,     0, 0,     1, 0, 1, 'h58,  0, 1, 0);
    tbl[20] = mk(0, 0,     0, 0,     1, 0, 0, 0,     0, 1, 0);
    tbl[21] = mk(0, 0,     0, 0,     1, 0, 0, 0,     1, 0, 1);
    tbl[22] = mk(0, 0,     0, 0,     1, 1, 0, 0,     1, 0, 0);
    tbl[23] = mk(0, 0,     0, 0,     1, 1, 0, 0,     0, 1, 0);
    tbl[24] = mk(0, 0,     0, 0,     1, 0, 0, 0,     1, 0, 1);
    tbl[25] = mk(0, 0,     0, 0,     1, 0, 0, 0,     1, 0, 0);

    next_cycle();
    next_cycle();
    chk("rst_upd_en", upd_en, 0);
    chk("rst_c_ready", c_ready, 1);
    chk("rst_busy", drain_busy, 0);
    chk("rst_done", drain_done, 0);
    chk("rst_upd_pc", upd_pc, 0);
    resetn = 1'b1;

    foreach (tbl[i]) begin
      drive_slots(tbl[i].c0v, tbl[i].c0pc, tbl[i].c1v, tbl[i].c1pc);
      upd_ready = tbl[i].rdy;
      drain_req = tbl[i].dreq;
      chk($sformatf("vec%0d_upd_en", i), upd_en, tbl[i].e_en);
      chk($sformatf("vec%0d_upd_pc", i), upd_pc, tbl[i].e_pc);
      chk($sformatf("vec%0d_upd_target", i), upd_target,
          tbl[i].e_en ? tbl[i].e_pc + 32'h100 : 32'h0);
      chk($sformatf("vec%0d_c_ready", i), c_ready, tbl[i].e_cr);
      chk($sformatf("vec%0d_busy", i), drain_busy, tbl[i].e_busy);
      chk($sformatf("vec%0d_done", i), drain_done, tbl[i].e_done);
      next_cycle();
    end
    drain_req = 1'b0;

    // Ten single commits through a ready signal that toggles every cycle.
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 200 && recv < 10; cyc++) begin
      drive_slots(sent < 10, 32'h1000 + 32'(sent) * 4, 0, 0);
      upd_ready = cyc[0];
      if (upd_en && upd_ready) begin
        exp_pc = 32'h1000 + 32'(recv) * 4;
        chk($sformatf("wrap_pc%0d", recv), upd_pc, exp_pc);
        recv++;
      end
      if (c_ready && c0_valid) sent++;
      next_cycle();
    end
    chk("wrap_count", recv, 10);
    drive_slots(0, 0, 0, 0);
    upd_ready = 1'b1;
    next_cycle();
    chk("wrap_empty", upd_en, 0);

    // Reset in the middle of a drain with two entries pending.
    upd_ready = 1'b0;
    drive_slots(1, 32'h200, 1, 32'h204);
    next_cycle();
    drive_slots(0, 0, 0, 0);
    drain_req = 1'b1;
    next_cycle();
    drain_req = 1'b0;
    chk("mid_busy", drain_busy, 1);
    chk("mid_en", upd_en, 1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_en", upd_en, 0);
    chk("mid_rst_busy", drain_busy, 0);
    chk("mid_rst_done", drain_done, 0);
    chk("mid_rst_c_ready", c_ready, 1);
    chk("mid_rst_pc", upd_pc, 0);
    next_cycle();
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("post_rst_done%0d", k), drain_done, 0);
      chk($sformatf("post_rst_en%0d", k), upd_en, 0);
      chk($sformatf("post_rst_c_ready%0d", k), c_ready, 1);
      next_cycle();
    end

    // Random traffic against the reference queue.
    mq.delete();
    m_busy = 1'b0; m_done = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      ent_t e0, e1;
      logic m_cr, m_en;
      e0.pc = $urandom; e0.target = $urandom; e0.taken = 1'($urandom);
      e0.typ = 2'($urandom); e0.bhr = 4'($urandom);
      e1.pc = $urandom; e1.target = $urandom; e1.taken = 1'($urandom);
      e1.typ = 2'($urandom); e1.bhr = 4'($urandom);
      c0_valid = 1'($urandom); c1_valid = 1'($urandom);
      c0_pc = e0.pc; c0_target = e0.target; c0_taken = e0.taken;
      c0_type = e0.typ; c0_bhr = e0.bhr;
      c1_pc = e1.pc; c1_target = e1.target; c1_taken = e1.taken;
      c1_type = e1.typ; c1_bhr = e1.bhr;
      upd_ready = ($urandom_range(3) != 0);
      drain_req = ($urandom_range(15) == 0);

      m_en = (mq.size() != 0);
      m_cr = ((4 - mq.size()) >= 2) && !m_busy;
      chk("rnd_upd_en", upd_en, m_en);
      chk("rnd_c_ready", c_ready, m_cr);
      chk("rnd_busy", drain_busy, m_busy);
      chk("rnd_done", drain_done, m_done);
      if (m_en) begin
        chk("rnd_pc", upd_pc, mq[0].pc);
        chk("rnd_target", upd_target, mq[0].target);
        chk("rnd_meta", {upd_taken, upd_type, upd_bhr},
            {mq[0].taken, mq[0].typ, mq[0].bhr});
      end

      if (m_done) m_done = 1'b0;
      else if (m_busy) begin
        if (mq.size() == 0) begin m_busy = 1'b0; m_done = 1'b1; end
      end else if (drain_req) m_busy = 1'b1;
      if (m_en && upd_ready) void'(mq.pop_front());
      if (m_cr && c0_valid) mq.push_back(e0);
      if (m_cr && c1_valid) mq.push_back(e1);
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
